cachelineresponder: RTL
=======================

# cachelineresponder

Line-granular bus responder that sits on the memory side of the cache bus interface (CacheBusRW/CacheBusAdr/CacheBusAck/BeatCount/SelBusBeat/FetchBuffer). It serves line fetches by filling FetchBuffer one beat per cycle. It serves dirty-line writebacks by sequencing BeatCount so the cache drives ReadDataWord for each beat. A private line store backs both operations. Its uses are a standalone cache testbench target and a zero-AHB fast-sim memory stub behind the I$/D$.

## Interface
Parameters:
- PA_BITS, 34: physical address width.
- LINELEN, 256: cache line bits.
- WORDLEN, 64: beat width. LINELEN/WORDLEN is a power of two ≥ 2.
- MEMLINES, 16: lines in backing store, power of two.
- LATENCY, 2: wait cycles before the first beat, ≥ 0.
- Derived:
  - BEATS = LINELEN/WORDLEN
  - LOGBWPL = $clog2(BEATS)
  - OFFSETLEN = $clog2(LINELEN/8)
  - MEMIDX = $clog2(MEMLINES)

Ports:
- clk, in, 1: clock. One clock domain.
- reset, in, 1: synchronous, active-high.
- CacheBusRW, in, 2: [1] line fetch, [0] line writeback. Held by the cache until ack.
- CacheBusAdr, in, PA_BITS: line address. Offset bits are ignored.
- ReadDataWord, in, WORDLEN: writeback beat data from the cache, valid in the cycle its BeatCount is presented.
- CacheBusAck, out, 1: high in the final beat cycle of an operation.
- SelBusBeat, out, 1: high during every beat cycle.
- BeatCount, out, LOGBWPL: current beat index.
- FetchBuffer, out, LINELEN: assembled fetched line.
- BusBusy, out, 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, WAIT, READBURST, WRITEBURST.
- Store: MEMLINES × LINELEN register array.
  - Index = CacheBusAdr[OFFSETLEN +: MEMIDX]. Upper address bits alias.
  - Not cleared by reset.
- Request decode in IDLE when CacheBusRW ≠ 00:
  - Bit 0 set selects writeback. 11 is illegal and is treated as writeback. The bench flags it.
  - Otherwise fetch.
- Latched at acceptance: index and op. CacheBusAdr changes after acceptance are ignored.
- IDLE → WAIT if LATENCY > 0, else directly to READBURST or WRITEBURST.
- WAIT: a latency counter counts LATENCY cycles, then moves to the selected burst state.
- READBURST, beat k:
  - At the clock edge, FetchBuffer[k*WORDLEN +: WORDLEN] ← store[idx][k*WORDLEN +: WORDLEN].
  - Beat order is always 0..BEATS-1 (no critical-word-first).
- WRITEBURST, beat k:
  - At the clock edge, store[idx][k*WORDLEN +: WORDLEN] ← ReadDataWord.
- BeatCount:
  - Holds 0 outside bursts.
  - Increments each beat cycle.
  - Wraps to 0 after beat BEATS-1.
- Last beat (BeatCount == BEATS-1): CacheBusAck = 1, then next state is IDLE.
- Abort: if CacheBusRW == 00 while in WAIT, return to IDLE. No store or FetchBuffer change, no ack.
- Once a burst starts it always completes. Deassertion mid-burst is ignored.
- FetchBuffer holds its value between fetches. Writebacks do not alter it.
- Read-after-write to the same index returns the written data. This includes a fetch requested the cycle after a writeback ack (the cachefsm writeback→fetch sequence).

## Timing
- Cycle 0 is the IDLE cycle in which CacheBusRW ≠ 00 is sampled.
- WAIT occupies cycles 1..LATENCY.
- Beats occupy cycles LATENCY+1 .. LATENCY+BEATS.
- Ack is at cycle LATENCY+BEATS. Total latency is LATENCY+BEATS+1 cycles including the request cycle.
- The complete FetchBuffer is visible in the cycle after ack.
- The next request can be accepted at cycle LATENCY+BEATS+1. There is no dead cycle.
- CacheBusAck, SelBusBeat, BeatCount and BusBusy are decoded from registered state and counter only. They have no combinational path from inputs.
- ReadDataWord has a same-cycle combinational dependence in the cache on BeatCount/SelBusBeat. The responder only samples it at the edge.
- Reset values:
  - state = IDLE
  - CacheBusAck = 0, SelBusBeat = 0, BusBusy = 0
  - BeatCount = 0, latency counter = 0
  - FetchBuffer = 0
- Reset mid-operation: return to IDLE immediately. Store beats written before the reset edge persist. Remaining beats are dropped and no ack is issued.

## Test plan
Defaults: LINELEN=256, WORDLEN=64, LATENCY=2, MEMLINES=16.

- Writeback then fetch:
  - Stimulus: writeback to CacheBusAdr=0x80000040 (idx 2), beats 0..3 = 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - Required: ack at cycle 6.
  - Stimulus: fetch of the same address issued at cycle 7.
  - Required: ack at cycle 13; FetchBuffer = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- LATENCY=0 build:
  - Stimulus: fetch.
  - Required: SelBusBeat is high in cycles 1–4 with BeatCount 0,1,2,3; ack in cycle 4; BusBusy is low in cycle 5.
- Abort:
  - Stimulus: fetch raised, then dropped in cycle 1 (WAIT).
  - Required: IDLE in cycle 2, no ack, FetchBuffer unchanged.
- Mid-burst deassert:
  - Stimulus: drop CacheBusRW at beat 1 of a writeback.
  - Required: all 4 beats are still written and ack is still issued.
- Reset during WRITEBURST:
  - Stimulus: reset after beat 1.
  - Required: beats 0–1 are updated in the store; beats 2–3 keep their old data; all outputs read 0 the cycle after reset.
- Aliasing and illegal op:
  - Stimulus: writeback to 0x0000_0400 (idx 0), then fetch of 0x0000_0000.
  - Required: the fetch returns the written data.
  - Stimulus: CacheBusRW=11.
  - Required: behaves as a writeback; the bench flags an error.

Source files
------------

// File: rtl/cachelineresponder_if.sv
// Cache-side line bus: request/address/writeback data in, beat sequencing and
// the assembled fetch line out.
interface cachelineresponder_if #(
    parameter int PA_BITS = 34,
    parameter int LINELEN = 256,
    parameter int WORDLEN = 64
);
    localparam int LOGBWPL = $clog2(LINELEN / WORDLEN);

    logic [1:0]         CacheBusRW;
    logic [PA_BITS-1:0] CacheBusAdr;
    logic [WORDLEN-1:0] ReadDataWord;
    logic               CacheBusAck;
    logic               SelBusBeat;
    logic [LOGBWPL-1:0] BeatCount;
    logic [LINELEN-1:0] FetchBuffer;
    logic               BusBusy;

    modport master (
        output CacheBusRW, CacheBusAdr, ReadDataWord,
        input  CacheBusAck, SelBusBeat, BeatCount, FetchBuffer, BusBusy
    );

    modport slave (
        input  CacheBusRW, CacheBusAdr, ReadDataWord,
        output CacheBusAck, SelBusBeat, BeatCount, FetchBuffer, BusBusy
    );
endinterface

// File: rtl/cachelineresponder.sv
// Memory-side line responder: fills FetchBuffer beat by beat on fetches and
// captures ReadDataWord beats into a private line store on writebacks.
module cachelineresponder #(
    parameter int PA_BITS  = 34,
    parameter int LINELEN  = 256,
    parameter int WORDLEN  = 64,
    parameter int MEMLINES = 16,
    parameter int LATENCY  = 2
) (
    input logic clk,
    input logic reset,
    cachelineresponder_if.slave bus
);
    localparam int BEATS     = LINELEN / WORDLEN;
    localparam int LOGBWPL   = $clog2(BEATS);
    localparam int OFFSETLEN = $clog2(LINELEN / 8);
    localparam int MEMIDX    = $clog2(MEMLINES);
    localparam int LOGW      = $clog2(WORDLEN);
    localparam int LATW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READBURST,
        WRITEBURST
    } stateT;

    stateT state, nextState, reqState;

    logic [LOGBWPL-1:0]      beatCnt, beatCntN;
    logic [LATW-1:0]         latCnt, latCntN;
    logic [MEMIDX-1:0]       idxR;
    logic                    isWrite;
    logic [LINELEN-1:0]      fetchBuf;
    logic [LINELEN-1:0]      store [MEMLINES];
    logic [LOGBWPL+LOGW-1:0] beatOfs;
    logic                    reqOn, accept, inBurst, lastBeat;
    logic                    unusedAdrBits;

    assign unusedAdrBits = ^{bus.CacheBusAdr[PA_BITS-1:OFFSETLEN+MEMIDX],
                             bus.CacheBusAdr[OFFSETLEN-1:0]};

    assign reqOn    = |bus.CacheBusRW;
    assign accept   = (state == IDLE) && reqOn;
    assign inBurst  = (state == READBURST) || (state == WRITEBURST);
    assign lastBeat = inBurst && (beatCnt == LOGBWPL'(BEATS - 1));
    assign beatOfs  = {beatCnt, {LOGW{1'b0}}};
    // 2'b11 is illegal; bit 0 wins so it degrades to a writeback
    assign reqState = bus.CacheBusRW[0] ? WRITEBURST : READBURST;

    always_comb begin
        nextState = state;
        latCntN   = latCnt;
        beatCntN  = beatCnt;
        unique case (state)
            IDLE: begin
                if (reqOn) begin
                    latCntN   = '0;
                    nextState = (LATENCY > 0) ? WAIT : reqState;
                end
            end
            WAIT: begin
                if (!reqOn) begin
                    latCntN   = '0;
                    nextState = IDLE;
                end else if (int'(latCnt) == LATENCY - 1) begin
                    latCntN   = '0;
                    nextState = isWrite ? WRITEBURST : READBURST;
                end else begin
                    latCntN = latCnt + 1'b1;
                end
            end
            READBURST, WRITEBURST: begin
                beatCntN = beatCnt + 1'b1;
                if (lastBeat) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            beatCnt  <= '0;
            latCnt   <= '0;
            idxR     <= '0;
            isWrite  <= 1'b0;
            fetchBuf <= '0;
        end else begin
            state   <= nextState;
            beatCnt <= beatCntN;
            latCnt  <= latCntN;
            if (accept) begin
                idxR    <= bus.CacheBusAdr[OFFSETLEN +: MEMIDX];
                isWrite <= bus.CacheBusRW[0];
            end
            if (state == READBURST)
                fetchBuf[beatOfs +: WORDLEN] <= store[idxR][beatOfs +: WORDLEN];
        end
    end

    // Store is never cleared; a reset edge only suppresses the pending beat
    always_ff @(posedge clk) begin
        if (!reset && state == WRITEBURST)
            store[idxR][beatOfs +: WORDLEN] <= bus.ReadDataWord;
    end

    assign bus.CacheBusAck = lastBeat;
    assign bus.SelBusBeat  = inBurst;
    assign bus.BeatCount   = beatCnt;
    assign bus.FetchBuffer = fetchBuf;
    assign bus.BusBusy     = (state != IDLE);
endmodule
